// File: rtl/stream_serializer_pkg.sv
// Shared helpers for the wide-to-narrow stream serializer.
// Only index-width sizing lives here; everything else is local to the block.
package stream_serializer_pkg;

    // Chunk index width for a given ratio; never narrower than one bit.
    function automatic int idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/stream_serializer.sv
// Wide-to-narrow valid/ready serializer: holds one input word and emits it
// as InWidth/OutWidth chunks, accepting the next word with the last chunk.
module stream_serializer
    import stream_serializer_pkg::*;
#(
    parameter int InWidth  = 32,
    parameter int OutWidth = 8,
    parameter bit MsbFirst = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din_valid,
    output logic                din_ready,
    input  logic [InWidth-1:0]  din_data,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic [OutWidth-1:0] dout_data,
    output logic                dout_last
);

    localparam int Ratio = InWidth / OutWidth;
    localparam int IdxW  = idx_width(Ratio);

    generate
        if ((InWidth % OutWidth) != 0 || Ratio < 1) begin : g_bad_ratio
            $error("stream_serializer: InWidth must be a positive multiple of OutWidth");
        end
    endgenerate

    logic [InWidth-1:0]  r_word;
    logic [IdxW-1:0]     r_idx;
    logic                r_valid;
    logic                w_last;
    logic                w_load;
    logic [OutWidth-1:0] w_data;

    assign w_last     = r_valid && (r_idx == IdxW'(Ratio - 1));
    assign din_ready  = !rst && (!r_valid || (dout_ready && w_last));
    assign w_load     = din_valid && din_ready;
    assign dout_valid = r_valid;
    assign dout_last  = w_last;
    assign dout_data  = w_data;

    // Unrolled mux keeps every part-select constant; chunk order flips with MsbFirst.
    always_comb begin
        w_data = '0;
        for (int c = 0; c < Ratio; c++) begin
            if (r_idx == IdxW'(c)) begin
                w_data = r_word[((MsbFirst != 1'b0) ? (Ratio - 1 - c) : c) * OutWidth +: OutWidth];
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            // Covers both an idle load and the same-cycle handoff on the last chunk.
            r_word  <= din_data;
            r_idx   <= '0;
            r_valid <= 1'b1;
        end else if (r_valid && dout_ready) begin
            if (w_last) begin
                r_idx   <= '0;
                r_valid <= 1'b0;
            end else begin
                r_idx   <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_serializer.sv
// Scoreboard bench for stream_serializer: LSB-first 32/8, MSB-first 32/8 and
// ratio-1 8/8 instances share one clock and reset.
module tb_stream_serializer;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // LSB-first 32->8
    logic        a_din_valid = 1'b0, a_din_ready, a_dout_valid, a_dout_ready = 1'b1, a_dout_last;
    logic [31:0] a_din_data = '0;
    logic [7:0]  a_dout_data;
    // MSB-first 32->8
    logic        b_din_valid = 1'b0, b_din_ready, b_dout_valid, b_dout_ready = 1'b1, b_dout_last;
    logic [31:0] b_din_data = '0;
    logic [7:0]  b_dout_data;
    // Ratio 1, 8->8
    logic        c_din_valid = 1'b0, c_din_ready, c_dout_valid, c_dout_ready = 1'b1, c_dout_last;
    logic [7:0]  c_din_data = '0;
    logic [7:0]  c_dout_data;

    exp_t a_q[$];
    exp_t b_q[$];
    exp_t c_q[$];

    stream_serializer #(.InWidth(32), .OutWidth(8), .MsbFirst(1'b0)) dut_lsb (
        .clk(clk), .rst(rst),
        .din_valid(a_din_valid), .din_ready(a_din_ready), .din_data(a_din_data),
        .dout_valid(a_dout_valid), .dout_ready(a_dout_ready),
        .dout_data(a_dout_data), .dout_last(a_dout_last)
    );

    stream_serializer #(.InWidth(32), .OutWidth(8), .MsbFirst(1'b1)) dut_msb (
        .clk(clk), .rst(rst),
        .din_valid(b_din_valid), .din_ready(b_din_ready), .din_data(b_din_data),
        .dout_valid(b_dout_valid), .dout_ready(b_dout_ready),
        .dout_data(b_dout_data), .dout_last(b_dout_last)
    );

    stream_serializer #(.InWidth(8), .OutWidth(8), .MsbFirst(1'b0)) dut_r1 (
        .clk(clk), .rst(rst),
        .din_valid(c_din_valid), .din_ready(c_din_ready), .din_data(c_din_data),
        .dout_valid(c_dout_valid), .dout_ready(c_dout_ready),
        .dout_data(c_dout_data), .dout_last(c_dout_last)
    );

    // Scoreboards: compare on each output handshake, then push chunks of each accepted word.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (a_dout_valid && a_dout_ready) begin
                checks++;
                if (a_q.size() == 0) begin
                    errors++;
                    $display("FAIL lsb_unexpected: got data=%h last=%b, expected no output", a_dout_data, a_dout_last);
                end else begin
                    e = a_q.pop_front();
                    if (a_dout_data !== e.data || a_dout_last !== e.last) begin
                        errors++;
                        $display("FAIL lsb_chunk: got data=%h last=%b, expected data=%h last=%b",
                                 a_dout_data, a_dout_last, e.data, e.last);
                    end
                end
            end
            if (a_din_valid && a_din_ready) begin
                for (int k = 0; k < 4; k++) begin
                    e.data = a_din_data[8*k +: 8];
                    e.last = (k == 3);
                    a_q.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (b_dout_valid && b_dout_ready) begin
                checks++;
                if (b_q.size() == 0) begin
                    errors++;
                    $display("FAIL msb_unexpected: got data=%h last=%b, expected no output", b_dout_data, b_dout_last);
                end else begin
                    e = b_q.pop_front();
                    if (b_dout_data !== e.data || b_dout_last !== e.last) begin
                        errors++;
                        $display("FAIL msb_chunk: got data=%h last=%b, expected data=%h last=%b",
                                 b_dout_data, b_dout_last, e.data, e.last);
                    end
                end
            end
            if (b_din_valid && b_din_ready) begin
                for (int k = 0; k < 4; k++) begin
                    e.data = b_din_data[8*(3-k) +: 8];
                    e.last = (k == 3);
                    b_q.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (c_dout_valid && c_dout_ready) begin
                checks++;
                if (c_q.size() == 0) begin
                    errors++;
                    $display("FAIL r1_unexpected: got data=%h last=%b, expected no output", c_dout_data, c_dout_last);
                end else begin
                    e = c_q.pop_front();
                    if (c_dout_data !== e.data || c_dout_last !== e.last) begin
                        errors++;
                        $display("FAIL r1_chunk: got data=%h last=%b, expected data=%h last=%b",
                                 c_dout_data, c_dout_last, e.data, e.last);
                    end
                end
            end
            if (c_din_valid && c_din_ready) begin
                e.data = c_din_data;
                e.last = 1'b1;
                c_q.push_back(e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        a_din_valid = 1'b1;
        a_din_data  = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (a_din_ready !== 1'b0 || b_din_ready !== 1'b0 || c_din_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: got %b%b%b, expected 000", a_din_ready, b_din_ready, c_din_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_din_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (a_dout_valid !== 1'b0 || a_dout_data !== 8'h00 || a_dout_last !== 1'b0 || a_din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h last=%b ready=%b, expected 0 00 0 1",
                     a_dout_valid, a_dout_data, a_dout_last, a_din_ready);
        end
        checks++;
        if (b_dout_valid !== 1'b0 || c_dout_valid !== 1'b0 || b_din_ready !== 1'b1 || c_din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs_bc: got b_valid=%b c_valid=%b b_ready=%b c_ready=%b, expected 0 0 1 1",
                     b_dout_valid, c_dout_valid, b_din_ready, c_din_ready);
        end
    endtask

    task automatic drain_a(input string name);
        int n = 0;
        a_dout_ready = 1'b1;
        while (a_dout_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        checks++;
        if (a_dout_valid !== 1'b0 || a_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got valid=%b pending=%0d, expected valid=0 pending=0", name, a_dout_valid, a_q.size());
        end
    endtask

    task automatic test_single_lsb();
        logic [7:0] exp_bytes[4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        @(posedge clk);
        #1;
        a_din_valid = 1'b1;
        a_din_data  = 32'hA1B2C3D4;
        @(posedge clk);
        #1;
        a_din_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (a_dout_valid !== 1'b1 || a_dout_data !== exp_bytes[k] || a_dout_last !== (k == 3)
                || a_din_ready !== (k == 3)) begin
                errors++;
                $display("FAIL lsb_single_k%0d: got valid=%b data=%h last=%b ready=%b, expected 1 %h %b %b",
                         k, a_dout_valid, a_dout_data, a_dout_last, a_din_ready, exp_bytes[k], k == 3, k == 3);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (a_dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL lsb_single_idle: got valid=%b, expected 0", a_dout_valid);
        end
    endtask

    task automatic test_single_msb();
        logic [7:0] exp_bytes[4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        @(posedge clk);
        #1;
        b_din_valid = 1'b1;
        b_din_data  = 32'hA1B2C3D4;
        @(posedge clk);
        #1;
        b_din_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (b_dout_valid !== 1'b1 || b_dout_data !== exp_bytes[k] || b_dout_last !== (k == 3)) begin
                errors++;
                $display("FAIL msb_single_k%0d: got valid=%b data=%h last=%b, expected 1 %h %b",
                         k, b_dout_valid, b_dout_data, b_dout_last, exp_bytes[k], k == 3);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (b_dout_valid !== 1'b0 || b_q.size() != 0) begin
            errors++;
            $display("FAIL msb_single_idle: got valid=%b pending=%0d, expected 0 0", b_dout_valid, b_q.size());
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk);
        #1;
        a_din_valid = 1'b1;
        a_din_data  = 32'h03020100;
        @(posedge clk);
        #1;
        a_din_data  = 32'h07060504;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (a_dout_valid !== 1'b1 || a_dout_data !== 8'(c) || a_din_ready !== ((c % 4) == 3)) begin
                errors++;
                $display("FAIL b2b_c%0d: got valid=%b data=%h ready=%b, expected 1 %h %b",
                         c, a_dout_valid, a_dout_data, a_din_ready, 8'(c), (c % 4) == 3);
            end
            @(posedge clk);
            #1;
            if (c == 3) a_din_valid = 1'b0;
        end
        drain_a("b2b");
    endtask

    task automatic test_backpressure();
        @(posedge clk);
        #1;
        a_din_valid = 1'b1;
        a_din_data  = 32'hA1B2C3D4;
        @(posedge clk);
        #1;
        a_din_valid = 1'b0;
        @(posedge clk);
        #1;
        a_dout_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            checks++;
            if (a_dout_valid !== 1'b1 || a_dout_data !== 8'hC3 || a_dout_last !== 1'b0 || a_din_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_s%0d: got valid=%b data=%h last=%b ready=%b, expected 1 c3 0 0",
                         s, a_dout_valid, a_dout_data, a_dout_last, a_din_ready);
            end
            @(posedge clk);
            #1;
        end
        drain_a("stall");
    endtask

    task automatic test_reset_mid_word();
        @(posedge clk);
        #1;
        a_din_valid = 1'b1;
        a_din_data  = 32'hA1B2C3D4;
        @(posedge clk);
        #1;
        a_din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (a_dout_data !== 8'hB2 || a_din_ready !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pre: got data=%h ready=%b, expected b2 0", a_dout_data, a_din_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_q.delete();
        @(negedge clk);
        checks++;
        if (a_dout_valid !== 1'b0 || a_din_ready !== 1'b1 || a_dout_data !== 8'h00) begin
            errors++;
            $display("FAIL midrst_post: got valid=%b ready=%b data=%h, expected 0 1 00",
                     a_dout_valid, a_din_ready, a_dout_data);
        end
        @(posedge clk);
        #1;
        a_din_valid = 1'b1;
        a_din_data  = 32'h11223344;
        @(posedge clk);
        #1;
        a_din_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (a_dout_valid !== 1'b1 || a_dout_data !== 8'h44) begin
            errors++;
            $display("FAIL midrst_first: got valid=%b data=%h, expected 1 44", a_dout_valid, a_dout_data);
        end
        drain_a("midrst");
    endtask

    task automatic test_ratio_one();
        logic acc;
        int   n = 0;
        int   sent = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            acc = c_din_valid && c_din_ready;
            if (acc) sent++;
            @(posedge clk);
            #1;
            if (!c_din_valid || acc) begin
                c_din_valid = ($urandom_range(0, 3) != 0);
                c_din_data  = 8'($urandom);
            end
            c_dout_ready = ($urandom_range(0, 2) != 0);
        end
        c_din_valid  = 1'b0;
        c_dout_ready = 1'b1;
        while (c_dout_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(negedge clk);
        checks++;
        if (c_dout_valid !== 1'b0 || c_q.size() != 0 || sent < 50) begin
            errors++;
            $display("FAIL r1_drain: got valid=%b pending=%0d sent=%0d, expected 0 0 >=50",
                     c_dout_valid, c_q.size(), sent);
        end
    endtask

    initial begin
        test_reset();
        test_single_lsb();
        test_single_msb();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_ratio_one();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
